// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

    localparam int NUM_SPOTS = 4;
    localparam int FREE_W    = 3;

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } gate_state_t;

    function automatic logic [FREE_W-1:0] free_spots(
        input logic [NUM_SPOTS-1:0] s
    );
        logic [FREE_W-1:0] taken;
        taken = '0;
        for (int i = 0; i < NUM_SPOTS; i++)
            taken = taken + {{(FREE_W-1){1'b0}}, s[i]};
        return FREE_W'(NUM_SPOTS) - taken;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter that parks at zero and flags it.
module gate_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Gate motor sequencer with beam safety reversal plus
// registered occupancy status and event counter.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 50,
    parameter int HOLD_CYCLES   = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              door_open_pulse,
    input  logic [3:0]        spots,
    input  logic              beam_blocked,
    output logic              motor_open,
    output logic              motor_close,
    output logic              gate_open_led,
    output logic              full_led,
    output logic [FREE_W-1:0] free_count,
    output logic [7:0]        events
);

    localparam int MAXC = (TRAVEL_CYCLES > HOLD_CYCLES) ?
                          TRAVEL_CYCLES : HOLD_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES - 1);

    gate_state_t   state;
    gate_state_t   state_nxt;
    logic          load;
    logic [TW-1:0] load_val;
    logic          zero;

    gate_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = TRAVEL_LD;
        unique case (state)
            CLOSED: begin
                if (door_open_pulse) begin
                    state_nxt = OPENING;
                    load      = 1'b1;
                end
            end
            OPENING: begin
                if (zero) begin
                    state_nxt = OPEN;
                    load      = 1'b1;
                    load_val  = HOLD_LD;
                end
            end
            OPEN: begin
                // Activity always rearms the hold, even on the expiry edge.
                if (door_open_pulse || beam_blocked) begin
                    load     = 1'b1;
                    load_val = HOLD_LD;
                end else if (zero) begin
                    state_nxt = CLOSING;
                    load      = 1'b1;
                end
            end
            CLOSING: begin
                if (door_open_pulse || beam_blocked) begin
                    state_nxt = OPENING;
                    load      = 1'b1;
                end else if (zero) begin
                    state_nxt = CLOSED;
                end
            end
            default: state_nxt = CLOSED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= CLOSED;
        else
            state <= state_nxt;
    end

    assign motor_open    = (state == OPENING);
    assign motor_close   = (state == CLOSING);
    assign gate_open_led = (state == OPEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_count <= FREE_W'(NUM_SPOTS);
            full_led   <= 1'b0;
            events     <= '0;
        end else begin
            free_count <= free_spots(spots);
            full_led   <= &spots;
            if (door_open_pulse)
                events <= events + 8'd1;
        end
    end

endmodule
